// File: rtl/bridge_timeout_watchdog.sv
// bridge_timeout_watchdog
//
// Multi-channel timeout and stall watchdog that sits beside the UART-AXI4
// bridge core. Each channel tracks a start/done transaction pair against a
// run-time cycle limit. A separate detector flags the main state machine
// sitting busy with no progress and no state change. Every event is latched
// into sticky status, a registered interrupt, a first-error code and a
// saturating event count.
//
// Optional feature: define BRIDGE_WDT_AUTO_ABORT_EN to drive abort_req with a
// one-cycle pulse per event source. Without the macro abort_req is tied low
// and the status behaviour is unchanged.
//
// Event codes: 0x10+i for channel i, 0x20 for the stall detector.

module bridge_timeout_watchdog #(
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_WIDTH    = 24,
    parameter int STATE_W      = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CHANNELS-1:0]           chan_start,
    input  logic [NUM_CHANNELS-1:0]           chan_done,
    input  logic [NUM_CHANNELS*CNT_WIDTH-1:0] chan_limit,
    input  logic [CNT_WIDTH-1:0]              stall_limit,
    input  logic                              bridge_busy,
    input  logic [STATE_W-1:0]                main_state,
    input  logic                              progress,
    input  logic [NUM_CHANNELS:0]             irq_enable,
    input  logic                              status_clear,
    output logic [NUM_CHANNELS-1:0]           timeout_status,
    output logic                              stall_status,
    output logic                              irq,
    output logic [7:0]                        first_error_code,
    output logic [7:0]                        event_count,
    output logic [NUM_CHANNELS:0]             abort_req,
    output logic [NUM_CHANNELS-1:0]           chan_active
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_EXPIRED = 2'd2
    } chan_state_e;

    // Number of simultaneous events in one edge (at most 17 for 16 channels).
    function automatic logic [4:0] count_events(input logic [NUM_CHANNELS:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int k = 0; k <= NUM_CHANNELS; k++) begin
            c = c + {4'd0, v[k]};
        end
        return c;
    endfunction

    // Code of the highest-ranked event: lowest channel index wins, stall last.
    function automatic logic [7:0] event_code(input logic [NUM_CHANNELS:0] v);
        logic [7:0] code;
        logic       found;
        code  = v[NUM_CHANNELS] ? 8'h20 : 8'h00;
        found = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            code  = (v[k] && !found) ? (8'h10 + 8'(k)) : code;
            found = found | v[k];
        end
        return code;
    endfunction

    // Per-channel state. lim_r holds the limit captured at start so that a
    // limit change only takes effect on the next start.
    chan_state_e            state_r [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]   cnt_r   [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]   lim_r   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] chan_active_r;
    logic [NUM_CHANNELS-1:0] chan_exp_s;

    // Stall detector state.
    logic [CNT_WIDTH-1:0]   scnt_r;
    logic [STATE_W-1:0]     last_state_r;
    logic                   stall_hold_s;
    logic                   stall_ev_s;

    // Event logging.
    logic [NUM_CHANNELS:0]   ev_s;
    logic [4:0]              ev_num_s;
    logic [7:0]              base_count_s;
    logic [8:0]              count_sum_s;
    logic [7:0]              nxt_count_s;
    logic [7:0]              nxt_code_s;
    logic [NUM_CHANNELS-1:0] timeout_status_r;
    logic                    stall_status_r;
    logic                    irq_r;
    logic [7:0]              first_code_r;
    logic [7:0]              event_count_r;

    // Expiry condition per channel: armed, still enabled, no done/start this
    // edge (both outrank expiry) and the count has reached the captured limit.
    always_comb begin
        chan_exp_s = {NUM_CHANNELS{1'b0}};
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            chan_exp_s[i] = (state_r[i] == ST_ARMED) &&
                            (chan_limit[i*CNT_WIDTH +: CNT_WIDTH] != CNT_ZERO) &&
                            !chan_done[i] && !chan_start[i] &&
                            (cnt_r[i] == lim_r[i]);
        end
    end

    // Stall condition: busy, no progress pulse, state unchanged, detector on.
    always_comb begin
        stall_hold_s = bridge_busy && !progress &&
                       (main_state == last_state_r) &&
                       (stall_limit != CNT_ZERO);
        stall_ev_s   = stall_hold_s && (scnt_r == (stall_limit - CNT_ONE));
    end

    // Combine this edge's events; a clear in the same edge is applied first.
    always_comb begin
        ev_s         = {stall_ev_s, chan_exp_s};
        ev_num_s     = count_events(ev_s);
        base_count_s = status_clear ? 8'd0 : event_count_r;
        count_sum_s  = {1'b0, base_count_s} + {4'd0, ev_num_s};
        nxt_count_s  = count_sum_s[8] ? 8'hFF : count_sum_s[7:0];
        if ((base_count_s == 8'd0) && (ev_num_s != 5'd0)) begin
            nxt_code_s = event_code(ev_s);
        end else begin
            nxt_code_s = status_clear ? 8'h00 : first_code_r;
        end
    end

    // Channel FSMs: IDLE / ARMED / EXPIRED with per-channel cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_r[i]       <= ST_IDLE;
                cnt_r[i]         <= CNT_ZERO;
                lim_r[i]         <= CNT_ZERO;
                chan_active_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                case (state_r[i])
                    ST_IDLE: begin
                        // Done is meaningless without an open transaction.
                        if (chan_start[i] && (chan_limit[i*CNT_WIDTH +: CNT_WIDTH] != CNT_ZERO)) begin
                            state_r[i]       <= ST_ARMED;
                            cnt_r[i]         <= CNT_ONE;
                            lim_r[i]         <= chan_limit[i*CNT_WIDTH +: CNT_WIDTH];
                            chan_active_r[i] <= 1'b1;
                        end else begin
                            state_r[i]       <= ST_IDLE;
                            chan_active_r[i] <= 1'b0;
                        end
                    end
                    ST_ARMED: begin
                        if (chan_limit[i*CNT_WIDTH +: CNT_WIDTH] == CNT_ZERO) begin
                            // Channel disabled under an open transaction.
                            state_r[i]       <= ST_IDLE;
                            cnt_r[i]         <= CNT_ZERO;
                            chan_active_r[i] <= 1'b0;
                        end else if (chan_start[i]) begin
                            // Re-arm; with a simultaneous done this is a
                            // back-to-back transaction.
                            state_r[i]       <= ST_ARMED;
                            cnt_r[i]         <= CNT_ONE;
                            lim_r[i]         <= chan_limit[i*CNT_WIDTH +: CNT_WIDTH];
                            chan_active_r[i] <= 1'b1;
                        end else if (chan_done[i]) begin
                            state_r[i]       <= ST_IDLE;
                            cnt_r[i]         <= CNT_ZERO;
                            chan_active_r[i] <= 1'b0;
                        end else if (chan_exp_s[i]) begin
                            state_r[i]       <= ST_EXPIRED;
                            chan_active_r[i] <= 1'b0;
                        end else begin
                            cnt_r[i]         <= cnt_r[i] + CNT_ONE;
                            chan_active_r[i] <= 1'b1;
                        end
                    end
                    ST_EXPIRED: begin
                        if (chan_done[i]) begin
                            // Late completion: no further event.
                            state_r[i]       <= ST_IDLE;
                            cnt_r[i]         <= CNT_ZERO;
                            chan_active_r[i] <= 1'b0;
                        end else if (chan_start[i] && (chan_limit[i*CNT_WIDTH +: CNT_WIDTH] != CNT_ZERO)) begin
                            state_r[i]       <= ST_ARMED;
                            cnt_r[i]         <= CNT_ONE;
                            lim_r[i]         <= chan_limit[i*CNT_WIDTH +: CNT_WIDTH];
                            chan_active_r[i] <= 1'b1;
                        end else if (chan_start[i]) begin
                            // Start on a disabled channel behaves as in IDLE.
                            state_r[i]       <= ST_IDLE;
                            cnt_r[i]         <= CNT_ZERO;
                            chan_active_r[i] <= 1'b0;
                        end else begin
                            state_r[i]       <= ST_EXPIRED;
                            chan_active_r[i] <= 1'b0;
                        end
                    end
                    default: begin
                        state_r[i]       <= ST_IDLE;
                        cnt_r[i]         <= CNT_ZERO;
                        chan_active_r[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Stall counter: restarts on idle, progress or state change, and after
    // each firing so a persistent stall re-fires every stall_limit cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_r       <= CNT_ZERO;
            last_state_r <= main_state;
        end else begin
            last_state_r <= main_state;
            if (stall_hold_s && !stall_ev_s) begin
                scnt_r <= scnt_r + CNT_ONE;
            end else begin
                scnt_r <= CNT_ZERO;
            end
        end
    end

    // Sticky status, first code, saturating count and registered interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_status_r <= {NUM_CHANNELS{1'b0}};
            stall_status_r   <= 1'b0;
            irq_r            <= 1'b0;
            first_code_r     <= 8'h00;
            event_count_r    <= 8'h00;
        end else begin
            timeout_status_r <= (status_clear ? {NUM_CHANNELS{1'b0}} : timeout_status_r) | chan_exp_s;
            stall_status_r   <= (status_clear ? 1'b0 : stall_status_r) | stall_ev_s;
            irq_r            <= |({stall_status_r, timeout_status_r} & irq_enable);
            first_code_r     <= nxt_code_s;
            event_count_r    <= nxt_count_s;
        end
    end

`ifdef BRIDGE_WDT_AUTO_ABORT_EN
    logic [NUM_CHANNELS:0] abort_r;

    // One-cycle abort pulse, aligned with the status bit becoming visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            abort_r <= {(NUM_CHANNELS+1){1'b0}};
        end else begin
            abort_r <= ev_s;
        end
    end

    assign abort_req = abort_r;
`else
    assign abort_req = {(NUM_CHANNELS+1){1'b0}};
`endif

    assign timeout_status   = timeout_status_r;
    assign stall_status     = stall_status_r;
    assign irq              = irq_r;
    assign first_error_code = first_code_r;
    assign event_count      = event_count_r;
    assign chan_active      = chan_active_r;

endmodule

// File: doc/bridge_timeout_watchdog.md
# bridge_timeout_watchdog

Synthesizable, multi-channel timeout and stall watchdog for the UART–AXI4 bridge. It sits beside the bridge core in the RTL, not the bench. It tracks NUM_CHANNELS independent start/done transaction pairs (frame response, AXI transaction, and spares) against run-time limits, and detects a busy-without-progress stall on the main state machine. Every event is latched into sticky status, an interrupt, a first-error code and a saturating event count; an optional one-cycle abort request lets the bridge recover instead of hanging.

## Interface
- NUM_CHANNELS, 4: number of start/done channels (1–16).
- CNT_WIDTH, 24: width of every timeout counter and limit.
- STATE_W, 3: width of the monitored main-state vector.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- chan_start  in  NUM_CHANNELS  per-channel start pulse.
- chan_done  in  NUM_CHANNELS  per-channel completion pulse.
- chan_limit  in  NUM_CHANNELS*CNT_WIDTH  per-channel limit in cycles. Channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH]. A value of 0 disables the channel.
- stall_limit  in  CNT_WIDTH  stall limit in cycles; 0 disables the stall detector.
- bridge_busy  in  1  bridge is processing.
- main_state  in  STATE_W  current bridge main state.
- progress  in  1  progress pulse (builder complete, frame consumed, parser error, …).
- irq_enable  in  NUM_CHANNELS+1  interrupt mask; bit NUM_CHANNELS is the stall bit.
- status_clear  in  1  clears sticky status, first code and event count.
- timeout_status  out  NUM_CHANNELS  sticky per-channel timeout flags.
- stall_status  out  1  sticky stall flag.
- irq  out  1  |({stall_status, timeout_status} & irq_enable), registered.
- first_error_code  out  8  code of the first event since clear.
- event_count  out  8  saturating count of events.
- abort_req  out  NUM_CHANNELS+1  one-cycle abort pulse per source (present only under the macro).
- chan_active  out  NUM_CHANNELS  channel is in ARMED.

## Operation
- Each channel runs its own FSM with states IDLE, ARMED and EXPIRED, and a counter cnt.
- IDLE:
  - chan_start with limit≠0 → ARMED, cnt←1.
  - chan_done is ignored.
- ARMED, evaluated in this priority order each edge:
  - done & start → stay ARMED, cnt←1 (back-to-back transaction).
  - done → IDLE.
  - start → re-arm, cnt←1.
  - cnt==limit → EXPIRED, set timeout_status[i], log event.
  - otherwise cnt←cnt+1.
- EXPIRED:
  - done → IDLE (late completion; no further event).
  - start → ARMED, cnt←1.
  - The sticky flag remains set until status_clear.
- A limit change takes effect on the next start. Writing limit=0 while ARMED forces the channel to IDLE.
- Stall detector:
  - scnt←0 when !bridge_busy, progress, or main_state≠last_state.
  - Otherwise, when scnt==stall_limit-1, set stall_status, log event and set scnt←0. A persistent stall therefore re-fires every stall_limit cycles.
  - Otherwise scnt←scnt+1.
- Event logging:
  - event_count increments and saturates at 255.
  - When event_count==0 before the event, first_error_code is loaded: 0x10+i for channel i, 0x20 for stall.
  - Simultaneous events: the lowest channel index wins the code, stall ranks last. event_count adds the number of simultaneous events and still saturates.
- status_clear together with a new event: the clear applies first, then the event is recorded. Status, code and count therefore reflect only the new event.
- Counter arithmetic is unsigned CNT_WIDTH bits. cnt never wraps because it stops at limit.

## Timing
- Reset values: all FSMs IDLE, cnt=scnt=0, timeout_status=0, stall_status=0, irq=0, first_error_code=0x00, event_count=0, abort_req=0, chan_active=0. last_state←main_state.
- Start sampled at edge E0: chan_done sampled at E1…E_L (L=limit) completes normally. Absent a done, the channel expires at E_L, so timeout_status[i] is high in the cycle after E_L.
- A done at E0 together with the start is not a completion.
- The stall flag asserts after stall_limit consecutive non-progress busy edges.
- irq rises one cycle after the corresponding status bit.
- abort_req[i] is high for exactly the one cycle in which the status bit first becomes visible for that event.
- Reset mid-operation aborts every counter in the same edge; no event is logged.

## Configuration
- BRIDGE_WDT_AUTO_ABORT_EN defined: abort_req is driven as described in Timing.
- Undefined: abort_req is tied to 0 and contains no logic; all status behaviour is identical.

## Test plan
- limit0=10, start at E0, done at E10 → no timeout, chan_active drops after E10, event_count=0.
- limit1=5, start, no done → timeout_status=0b0010 after E5, first_error_code=0x11, event_count=1, irq one cycle later when enabled. With the macro, abort_req[1] pulses once.
- Channels 0 and 2 expire on the same edge → first_error_code=0x10, event_count=2. A late done on channel 2 → IDLE, status bit stays set.
- stall_limit=8, bridge_busy held high with constant state → stall_status after 8 edges, code=0x20. Held for 24 edges → event_count=3. A state change at edge 7 → no event.
- status_clear on the same edge as a channel 3 expiry → status=0b1000, code=0x13, count=1. 300 events → event_count=255.
- rst asserted mid-ARMED → all outputs return to reset values at the next edge; limit=0 with a start → channel stays IDLE.
